// File: rtl/booth_pkg.sv
// Shared types and constants for the booth multiply-accumulate result stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package booth_pkg;

    // Width of each signed product arriving from the multiplier stage.
    localparam int PROD_W    = 8;
    // Default accumulator / result width; legal range 8..32.
    localparam int ACC_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } booth_state_t;

endpackage

// File: rtl/booth_mac_acc_if.sv
// Product-in / result-out valid-ready bundle for booth_mac_acc.
// Latency: n/a (wiring only).
// Backpressure: in_ready throttles the producer, out_ready throttles the result.
// Ports (signals):
//   in_valid / in_product / in_ready : product stream from the multiplier stage
//   out_valid / out_ready / out_sum / out_ovf : accumulated result stream
// Modports: master = producer/consumer side, slave = booth_mac_acc.
interface booth_mac_acc_if
    import booth_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);
    logic              in_valid;
    logic [PROD_W-1:0] in_product;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output in_valid, in_product, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_product, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/booth_sat_add.sv
// Signed accumulate adder: acc + sext(product) with overflow flag, wrap or saturate.
// Latency: combinational.
// Backpressure: none.
// Ports: i_acc (ACC_W signed), i_prod (PROD_W signed) -> o_sum (ACC_W), o_ovf.
// Build option: BOOTH_ACC_SAT_EN selects saturation; otherwise the sum wraps.
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic signed [PROD_W-1:0] i_prod,
    output logic        [ACC_W-1:0]  o_sum,
    output logic                     o_ovf
);

    logic signed [ACC_W:0] w_a;
    logic signed [ACC_W:0] w_b;
    logic signed [ACC_W:0] w_full;

    // One guard bit is enough: a single add can move at most one bit past ACC_W.
    assign w_a    = (ACC_W+1)'(i_acc);
    assign w_b    = (ACC_W+1)'(i_prod);
    assign w_full = w_a + w_b;

    // Guard bit disagreeing with the result MSB means the true sum left range.
    assign o_ovf  = w_full[ACC_W] ^ w_full[ACC_W-1];

`ifdef BOOTH_ACC_SAT_EN
    // Guard bit carries the sign of the true sum, which picks the clamp rail.
    always_comb begin
        o_sum = w_full[ACC_W-1:0];
        if (o_ovf) begin
            o_sum = w_full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/booth_mac_acc.sv
// Accumulates acc_len signed products into one result and holds it until taken.
// Latency: out_valid rises 1 cycle after the final product transfer.
// Backpressure: in_ready low while a result is held; result held until out_ready.
// Ports: clk, resetn (async active-low), clear (sync abort), acc_len (0 => 16),
//        bus (booth_mac_acc_if.slave): product in / result out handshakes.
// Build option: BOOTH_ACC_SAT_EN saturates on overflow instead of wrapping.
module booth_mac_acc
    import booth_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clear,
    input  logic [3:0]      acc_len,
    booth_mac_acc_if.slave  bus
);

    booth_state_t      r_state;
    booth_state_t      w_next_state;
    logic [ACC_W-1:0]  r_acc;
    logic [4:0]        r_cnt;
    logic [4:0]        r_len;
    logic              r_ovf;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic [4:0]        w_len_in;
    logic [4:0]        w_cnt_inc;
    logic [ACC_W-1:0]  w_prod_ext;
    logic [ACC_W-1:0]  w_sum;
    logic              w_add_ovf;

    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = w_out_valid && bus.out_ready;
    // A length field of zero encodes the maximum of 16 products.
    assign w_len_in   = (acc_len == 4'd0) ? 5'd16 : {1'b0, acc_len};
    assign w_cnt_inc  = r_cnt + 5'd1;
    assign w_prod_ext = ACC_W'($signed(bus.in_product));

    booth_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .i_acc  (r_acc),
        .i_prod (bus.in_product),
        .o_sum  (w_sum),
        .o_ovf  (w_add_ovf)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; clear overrides every other event.
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_xfer) begin
                        w_next_state = (w_len_in == 5'd1) ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_in_xfer && (w_cnt_inc == r_len)) begin
                        w_next_state = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_out_xfer) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs are pure functions of the state.
    always_comb begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        case (r_state)
            ST_HOLD: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b1;
            end
            default: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b0;
            end
        endcase
    end

    // Accumulator datapath. The length is captured on the first product so
    // later acc_len changes cannot shorten or stretch a result in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= 5'd1;
            r_ovf <= 1'b0;
        end else if (clear) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_in_xfer) begin
            if (r_state == ST_IDLE) begin
                r_acc <= w_prod_ext;
                r_cnt <= 5'd1;
                r_len <= w_len_in;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_inc;
                r_ovf <= r_ovf | w_add_ovf;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_sum   = r_acc;
    assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Bench for booth_mac_acc: two instances (ACC_W=16 and ACC_W=8) share stimulus.
// Latency: expects out_valid 1 cycle after the last product of a result.
// Backpressure: random out_ready stalls; in_ready must drop while a result is held.
module tb_booth_mac_acc;
    import booth_pkg::*;

    logic       clk;
    logic       resetn;
    logic       clear;
    logic [3:0] acc_len;
    logic       in_valid;
    logic [7:0] in_product;
    logic       out_ready;

    int errors = 0;
    int checks = 0;
    bit run_chk = 0;

    booth_mac_acc_if #(.ACC_W(16)) if16 ();
    booth_mac_acc_if #(.ACC_W(8))  if8  ();

    assign if16.in_valid   = in_valid;
    assign if16.in_product = in_product;
    assign if16.out_ready  = out_ready;
    assign if8.in_valid    = in_valid;
    assign if8.in_product  = in_product;
    assign if8.out_ready   = out_ready;

    booth_mac_acc #(.ACC_W(16)) u_dut16 (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (clear),
        .acc_len (acc_len),
        .bus     (if16)
    );

    booth_mac_acc #(.ACC_W(8)) u_dut8 (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (clear),
        .acc_len (acc_len),
        .bus     (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The result is the list of products accepted so far; the expected sum is
    // folded from that list with plain integer arithmetic when checked.
    bit m_hold;
    int m_n;
    int m_len;
    int m_prods [16];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_hold = 0;
            m_n    = 0;
        end else if (clear) begin
            m_hold = 0;
            m_n    = 0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold = 0;
                m_n    = 0;
            end
        end else if (in_valid) begin
            if (m_n == 0) m_len = (acc_len == 4'd0) ? 16 : int'(acc_len);
            m_prods[m_n] = int'($signed(in_product));
            m_n++;
            if (m_n == m_len) m_hold = 1;
        end
    end

    function automatic longint fold(input int w, output bit ovf);
        longint mx, mn, acc, t;
        mx  = (longint'(1) << (w - 1)) - 1;
        mn  = -mx - 1;
        acc = m_prods[0];
        ovf = 0;
        for (int i = 1; i < m_n; i++) begin
            t = acc + m_prods[i];
            if (t > mx || t < mn) begin
                ovf = 1;
`ifdef BOOTH_ACC_SAT_EN
                t = (t > mx) ? mx : mn;
`else
                t = (t > mx) ? t - (mx - mn + 1) : t + (mx - mn + 1);
`endif
            end
            acc = t;
        end
        return acc;
    endfunction

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            longint s16, s8;
            bit o16, o8;
            chk("in_ready16",  longint'(if16.in_ready),  longint'(!m_hold));
            chk("out_valid16", longint'(if16.out_valid), longint'(m_hold));
            chk("in_ready8",   longint'(if8.in_ready),   longint'(!m_hold));
            chk("out_valid8",  longint'(if8.out_valid),  longint'(m_hold));
            if (m_hold) begin
                s16 = fold(16, o16);
                s8  = fold(8, o8);
                chk("sum16", longint'($signed(if16.out_sum)), s16);
                chk("ovf16", longint'(if16.out_ovf), longint'(o16));
                chk("sum8",  longint'($signed(if8.out_sum)),  s8);
                chk("ovf8",  longint'(if8.out_ovf),  longint'(o8));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int p);
        in_valid   = 1'b1;
        in_product = 8'(p);
        @(posedge clk); #1;
        in_valid   = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        clear      = 1'b0;
        acc_len    = 4'd0;
        in_valid   = 1'b0;
        in_product = 8'd0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        run_chk = 1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready",  longint'(if16.in_ready), 1);
        chk("rst_out_valid", longint'(if16.out_valid), 0);
        chk("rst_out_sum",   longint'(if16.out_sum), 0);
        chk("rst_out_ovf",   longint'(if16.out_ovf), 0);
        @(posedge clk); #1;

        // Four products back to back: 10 - 3 + 64 - 56 = 15
        acc_len = 4'd4;
        send(10); send(-3); send(64);
        acc_len = 4'd1;            // must not affect the result in flight
        send(-56);
        @(negedge clk);
        chk("len4_valid", longint'(if16.out_valid), 1);
        chk("len4_sum",   longint'(if16.out_sum), 15);
        chk("len4_ovf",   longint'(if16.out_ovf), 0);
        take();

        // Single product -8 -> 0xFFF8, back to IDLE after the take
        acc_len = 4'd1;
        send(-8);
        @(negedge clk);
        chk("len1_valid", longint'(if16.out_valid), 1);
        chk("len1_sum",   longint'(if16.out_sum), 'hFFF8);
        take();
        @(negedge clk);
        chk("len1_idle_rdy", longint'(if16.in_ready), 1);
        chk("len1_idle_vld", longint'(if16.out_valid), 0);
        @(posedge clk); #1;

        // Held result stays stable under a 5-cycle stall
        acc_len = 4'd2;
        send(5); send(6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", longint'(if16.in_ready), 0);
            chk("stall_sum",      longint'(if16.out_sum), 11);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_done_vld", longint'(if16.out_valid), 0);
        @(posedge clk); #1;

        // 100 + 100 overflows the 8-bit accumulator only
        acc_len = 4'd2;
        send(100); send(100);
        @(negedge clk);
`ifdef BOOTH_ACC_SAT_EN
        chk("ovf8_sum", longint'($signed(if8.out_sum)), 127);
`else
        chk("ovf8_sum", longint'($signed(if8.out_sum)), -56);
`endif
        chk("ovf8_flag",  longint'(if8.out_ovf), 1);
        chk("ovf16_sum",  longint'(if16.out_sum), 200);
        chk("ovf16_flag", longint'(if16.out_ovf), 0);
        take();

        // Clear mid-result drops partial sum and the coincident product
        acc_len = 4'd4;
        send(3); send(3);
        clear      = 1'b1;
        in_valid   = 1'b1;
        in_product = 8'd50;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_sum", longint'(if16.out_sum), 0);
        @(posedge clk); #1;
        acc_len = 4'd2;
        send(3); send(4);
        @(negedge clk);
        chk("clr_new_sum", longint'(if16.out_sum), 7);
        chk("clr_new_ovf", longint'(if16.out_ovf), 0);
        take();

        // Async reset while holding a result
        acc_len = 4'd1;
        send(5);
        @(negedge clk);
        chk("pre_rst_vld", longint'(if16.out_valid), 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_vld", longint'(if16.out_valid), 0);
        chk("arst_sum", longint'(if16.out_sum), 0);
        chk("arst_rdy", longint'(if16.in_ready), 1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        acc_len = 4'd1;
        send(9);
        @(negedge clk);
        chk("post_rst_sum", longint'(if16.out_sum), 9);
        take();

        // Randomised traffic; acc_len changes freely mid-result
        for (int c = 0; c < 1500; c++) begin
            in_valid   = ($urandom_range(3) != 0);
            in_product = 8'($urandom);
            acc_len    = ($urandom_range(3) == 0) ? 4'($urandom) : 4'($urandom_range(4));
            out_ready  = $urandom_range(1) == 1;
            clear      = ($urandom_range(59) == 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
